// File: rtl/load_store_unit.sv
// load_store_unit
//   Multi-cycle RV32I load/store initiator in front of a word-addressed data
//   memory. Accepts one request at a time. Byte and halfword stores become a
//   read-modify-write of the containing word. Load data comes back sign- or
//   zero-extended. Illegal funct3 codes (and, optionally, misaligned
//   addresses) complete as faults and never touch memory.
//
//   Optional feature: define LSU_ALIGN_CHECK_EN to make misaligned halfword
//   and word accesses fault. Without it, halfword accesses use lane addr[1]
//   and word accesses ignore addr[1:0].
//
//   Ports
//     clk, rst                      clock, synchronous active-high reset
//     req_valid/req_ready           request handshake
//     req_store, req_funct3,
//     req_addr, req_wdata           request fields, latched at handshake
//     resp_valid                    one-cycle completion pulse
//     resp_rdata, resp_fault        registered response, held until next request
//     mem_read, mem_write,
//     mem_addr, mem_wdata           word memory request (addr word-aligned)
//     mem_rdata                     combinational read data
module load_store_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_fault,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   state_t      state_q, state_d;
   logic        store_q, store_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] word_q, word_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        resp_fault_q, resp_fault_d;

   logic handshake;
   logic req_fault;

   // Sign/zero-extend the addressed lane of a memory word.
   function automatic logic [31:0] load_extract(input logic [2:0] f3,
                                                input logic [1:0] a,
                                                input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[8*a +: 8];
      h = a[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  return {{24{b[7]}}, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b100:  return {24'd0, b};
         3'b101:  return {16'd0, h};
         default: return w;
      endcase
   endfunction

   // Full write word: SW passes data, SB/SH splice into the captured word.
   function automatic logic [31:0] store_merge(input logic [1:0] sz,
                                               input logic [1:0] a,
                                               input logic [31:0] w,
                                               input logic [31:0] d);
      logic [31:0] m;
      m = w;
      case (sz)
         2'b00:   m[8*a +: 8] = d[7:0];
         2'b01:   if (a[1]) m[31:16] = d[15:0]; else m[15:0] = d[15:0];
         default: m = d;
      endcase
      return m;
   endfunction

   // Fault classification on the live request fields (used at handshake).
   always_comb begin
      req_fault = 1'b0;
      if (req_store)
         req_fault = req_funct3[2] | (req_funct3[1:0] == 2'b11);
      else
         req_fault = (req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11);
`ifdef LSU_ALIGN_CHECK_EN
      if (req_funct3[1:0] == 2'b01 && req_addr[0])
         req_fault = 1'b1;
      if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
         req_fault = 1'b1;
`endif
   end

   assign handshake = req_valid & req_ready;

   // State register
   always_ff @(posedge clk) begin
      state_q      <= state_d;
      store_q      <= store_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      word_q       <= word_d;
      resp_rdata_q <= resp_rdata_d;
      resp_fault_q <= resp_fault_d;
   end

   // Next-state and datapath
   always_comb begin
      state_d      = state_q;
      store_d      = store_q;
      funct3_d     = funct3_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      word_d       = word_q;
      resp_rdata_d = resp_rdata_q;
      resp_fault_d = resp_fault_q;
      case (state_q)
         IDLE: if (handshake) begin
            store_d      = req_store;
            funct3_d     = req_funct3;
            addr_d       = req_addr;
            wdata_d      = req_wdata;
            resp_rdata_d = 32'd0;
            resp_fault_d = req_fault;
            if (req_fault)
               state_d = RESP;
            else if (req_store && req_funct3[1:0] == 2'b10)
               state_d = WR;          // SW needs no read
            else
               state_d = RD;
         end
         RD: begin
            word_d = mem_rdata;
            if (store_q)
               state_d = WR;
            else begin
               resp_rdata_d = load_extract(funct3_q, addr_q[1:0], mem_rdata);
               state_d      = RESP;
            end
         end
         WR:      state_d = RESP;
         default: state_d = IDLE;
      endcase
      if (rst) begin
         state_d      = IDLE;
         store_d      = 1'b0;
         funct3_d     = 3'd0;
         addr_d       = 32'd0;
         wdata_d      = 32'd0;
         word_d       = 32'd0;
         resp_rdata_d = 32'd0;
         resp_fault_d = 1'b0;
      end
   end

   // Outputs; memory enables are gated by rst so an abort never lands a write.
   always_comb begin
      req_ready  = (state_q == IDLE) & ~rst;
      resp_valid = (state_q == RESP) & ~rst;
      mem_read   = (state_q == RD) & ~rst;
      mem_write  = (state_q == WR) & ~rst;
      mem_addr   = 32'd0;
      mem_wdata  = 32'd0;
      if (mem_read | mem_write)
         mem_addr = {addr_q[31:2], 2'b00};
      if (mem_write)
         mem_wdata = store_merge(funct3_q[1:0], addr_q[1:0], word_q, wdata_q);
   end

   assign resp_rdata = resp_rdata_q;
   assign resp_fault = resp_fault_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store initiator sitting between the RV32I execute stage and the word-addressed data memory. Accepts one load or store request at a time from the core, converts RV32I byte/halfword/word semantics into word-only memory transactions (read-modify-write for SB/SH), and returns sign- or zero-extended load data. Misaligned and illegal accesses are reported as faults with no memory side effects.

## Interface
- No parameters; data and address widths fixed at 32.
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  core request present
- req_ready  out  1  unit idle and can accept; handshake completes when req_valid & req_ready at the clk edge
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low byte/half used for SB/SH)
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; valid with resp_valid on loads, 0 for stores/faults
- resp_fault  out  1  valid with resp_valid: misaligned or illegal funct3
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable (written at next clk edge)
- mem_addr  out  32  word-aligned byte address ({addr[31:2],2'b00})
- mem_wdata  out  32  full write word
- mem_rdata  in  32  combinational read word, valid in the same cycle mem_read is high

## Operation
- FSM states: IDLE, RD, WR, RESP. Request fields latched at handshake.
- IDLE: req_ready=1. On handshake: fault -> RESP; load -> RD; SW -> WR; SB/SH -> RD.
- RD: mem_read=1, mem_addr=aligned addr; mem_rdata captured into word register at edge. Load -> RESP; SB/SH -> WR.
- WR: mem_write=1. SW: mem_wdata=req_wdata. SB: captured word with byte lane addr[1:0] replaced by wdata[7:0]. SH: half lane addr[1] replaced by wdata[15:0]. -> RESP.
- RESP: resp_valid=1 for exactly one cycle -> IDLE. req_ready=0 in RD, WR, RESP (no back-to-back acceptance in RESP).
- Load extraction: LB/LH sign-extend selected lane; LBU/LHU zero-extend; LW passes word. Lane = addr[1:0] for bytes, addr[1] for halves.
- Fault: funct3 not in the lists above (loads 011/110/111, stores 011 and 1xx), or misalignment (see Configuration). No mem_read/mem_write asserted for faulted requests; resp_rdata=0.
- mem_read/mem_write never both high. mem_addr/mem_wdata = 0 when neither enable is high.

## Timing
- Handshake edge = T0. resp_valid high in cycle: fault T0+1; LW/LB/LH/LBU/LHU T0+2; SW T0+2 (write lands at T0+2 edge); SB/SH T0+3.
- resp_rdata, resp_fault registered; held until next handshake, cleared on rst.
- Reset: state IDLE; resp_valid=0, resp_rdata=0, resp_fault=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0; req_ready=0 while rst high, 1 the cycle after.
- rst mid-operation (any state) aborts the request: mem_read/mem_write gated low while rst high, no resp_valid issued, next cycle IDLE.
- req_valid while not ready is ignored; request fields may change freely outside handshake.

## Configuration
- LSU_ALIGN_CHECK_EN defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, fault (resp_fault=1, no memory access).
- Not defined: no misalignment faults; halfword accesses use lane addr[1] (addr[0] ignored), word accesses ignore addr[1:0]. Illegal funct3 still faults.

## Test plan
- Reset then SW addr 0x10 data 0xDEADBEEF -> mem_write at T0+1, mem_addr 0x10, mem_wdata 0xDEADBEEF; LW 0x10 -> resp_rdata 0xDEADBEEF at T0+2.
- After above, LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
- SB 0x11 data 0x00000055 over 0xDEADBEEF -> RD then WR with mem_wdata 0xDEAD55EF, resp_valid at T0+3; SH 0x12 data 0x1234 -> word 0x123455EF.
- With LSU_ALIGN_CHECK_EN: LW 0x12 -> resp_fault=1 at T0+1, resp_rdata 0, no mem_read/mem_write ever high; without macro -> reads word 0x10.
- Illegal funct3 (load 011, store 100) -> resp_fault=1 at T0+1, no memory access.
- rst asserted during WR of an SB -> no resp_valid, mem_write low that cycle, req_ready=1 cycle after rst drops, all response outputs 0.
